alu_seq: RTL

Registered, handshaked successor to the combinational ALU, sitting between the decode/register-read stage and the writeback stage. It is parametrised in data width and in signed/unsigned compare mode. Results are held in an output register under valid/ready flow control, and an optional multicycle multiplier plus single-cycle shifts are added. It produces a data result and a 1-bit compare flag for branch resolution.

---
 rtl/alu_seq.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// alu_seq: registered, handshaked ALU with a valid/ready output register.
// It produces a data result, a compare/branch flag and an illegal-opcode flag.
// Optional feature macro: ALU_MUL_EN adds an iterative shift-add multiplier
// (opcode 23) with its own MUL state. Without it, opcode 23 is illegal.
module alu_seq #(
  parameter int DATA_WIDTH = 32,
  parameter bit SIGNED_CMP = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4:0]            in_op,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic                  out_compare,
  output logic                  out_illegal
);

  localparam int SW = $clog2(DATA_WIDTH);
  localparam int HW = DATA_WIDTH / 2;

  logic [DATA_WIDTH-1:0] result_reg, result_next;
  logic                  compare_reg, compare_next;
  logic                  illegal_reg, illegal_next;
  logic                  valid_reg, valid_next;

  logic [DATA_WIDTH-1:0] alu_result;
  logic                  alu_compare;
  logic                  alu_illegal;

  logic                  eq, lt, a_zero, a_neg;
  logic [SW-1:0]         shamt;
  logic                  accept, consume;

  assign eq     = (in_a == in_b);
  assign lt     = SIGNED_CMP ? ($signed(in_a) < $signed(in_b)) : (in_a < in_b);
  assign a_zero = (in_a == '0);
  assign a_neg  = in_a[DATA_WIDTH-1];
  assign shamt  = in_b[SW-1:0];

  // Single-cycle datapath: result, flag and legality for the presented opcode.
  always_comb begin
    alu_result  = '0;
    alu_compare = 1'b0;
    alu_illegal = 1'b0;
    case (in_op)
      5'd0:  alu_result = in_a + in_b;
      5'd1:  alu_result = in_a - in_b;
      5'd2:  alu_result = in_a & in_b;
      5'd3:  alu_result = in_a | in_b;
      5'd4:  alu_result = in_a ^ in_b;
      5'd5:  alu_result = ~(in_a & in_b);
      5'd6:  alu_result = ~(in_a | in_b);
      5'd7:  alu_result = ~(in_a ^ in_b);
      5'd8:  alu_result = {in_a[HW-1:0], {HW{1'b0}}};
      5'd9:  alu_compare = 1'b0;
      5'd10: alu_compare = eq;
      5'd11: alu_compare = lt;
      5'd12: alu_compare = lt | eq;
      5'd13: alu_compare = 1'b1;
      5'd14: alu_compare = ~eq;
      5'd15: alu_compare = ~lt;
      5'd16: alu_compare = ~(lt | eq);
      5'd17: alu_compare = a_zero;
      5'd18: alu_compare = a_neg;
      5'd19: alu_compare = a_neg | a_zero;
      5'd20: alu_compare = ~a_zero;
      5'd21: alu_compare = ~a_neg;
      5'd22: alu_compare = ~a_neg & ~a_zero;
      5'd24: alu_result = in_a << shamt;
      5'd25: alu_result = in_a >> shamt;
      5'd26: alu_result = DATA_WIDTH'($signed(in_a) >>> shamt);
      default: alu_illegal = 1'b1;
    endcase
    // Set-on-condition ops also return the flag in the data result.
    if (in_op >= 5'd9 && in_op <= 5'd16) begin
      alu_result = {{(DATA_WIDTH-1){1'b0}}, alu_compare};
    end
  end

  assign consume = valid_reg && out_ready;
  assign accept  = in_valid && in_ready;

`ifdef ALU_MUL_EN
  typedef enum logic {ST_IDLE, ST_MUL} state_t;

  state_t                state_reg, state_next;
  logic [DATA_WIDTH-1:0] mcand_reg, mcand_next;
  logic [DATA_WIDTH-1:0] mplier_reg, mplier_next;
  logic [DATA_WIDTH-1:0] acc_reg, acc_next;
  logic [SW-1:0]         count_reg, count_next;
  logic [DATA_WIDTH-1:0] acc_sum;

  assign in_ready = (state_reg == ST_IDLE) && (!valid_reg || out_ready);
  assign acc_sum  = acc_reg + (mplier_reg[0] ? mcand_reg : '0);

  // State register plus output and multiplier registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= ST_IDLE;
      valid_reg   <= 1'b0;
      result_reg  <= '0;
      compare_reg <= 1'b0;
      illegal_reg <= 1'b0;
      mcand_reg   <= '0;
      mplier_reg  <= '0;
      acc_reg     <= '0;
      count_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      valid_reg   <= valid_next;
      result_reg  <= result_next;
      compare_reg <= compare_next;
      illegal_reg <= illegal_next;
      mcand_reg   <= mcand_next;
      mplier_reg  <= mplier_next;
      acc_reg     <= acc_next;
      count_reg   <= count_next;
    end
  end

  // Next-state: accept single-cycle ops or start/step the multiplier.
  always_comb begin
    state_next   = state_reg;
    valid_next   = valid_reg;
    result_next  = result_reg;
    compare_next = compare_reg;
    illegal_next = illegal_reg;
    mcand_next   = mcand_reg;
    mplier_next  = mplier_reg;
    acc_next     = acc_reg;
    count_next   = count_reg;
    if (consume) valid_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          if (in_op == 5'd23) begin
            mcand_next  = in_a;
            mplier_next = in_b;
            acc_next    = '0;
            count_next  = '0;
            state_next  = ST_MUL;
          end else begin
            valid_next   = 1'b1;
            result_next  = alu_result;
            compare_next = alu_compare;
            illegal_next = alu_illegal;
          end
        end
      end
      ST_MUL: begin
        acc_next    = acc_sum;
        mcand_next  = mcand_reg << 1;
        mplier_next = mplier_reg >> 1;
        count_next  = count_reg + SW'(1);
        if (count_reg == SW'(DATA_WIDTH - 1)) begin
          valid_next   = 1'b1;
          result_next  = acc_sum;
          compare_next = 1'b0;
          illegal_next = 1'b0;
          state_next   = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end
`else
  assign in_ready = !valid_reg || out_ready;

  // Output register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_reg   <= 1'b0;
      result_reg  <= '0;
      compare_reg <= 1'b0;
      illegal_reg <= 1'b0;
    end else begin
      valid_reg   <= valid_next;
      result_reg  <= result_next;
      compare_reg <= compare_next;
      illegal_reg <= illegal_next;
    end
  end

  // Next-state: load on accept, drop valid on consume.
  always_comb begin
    valid_next   = valid_reg;
    result_next  = result_reg;
    compare_next = compare_reg;
    illegal_next = illegal_reg;
    if (consume) valid_next = 1'b0;
    if (accept) begin
      valid_next   = 1'b1;
      result_next  = alu_result;
      compare_next = alu_compare;
      illegal_next = alu_illegal;
    end
  end
`endif

  assign out_valid   = valid_reg;
  assign out_result  = result_reg;
  assign out_compare = compare_reg;
  assign out_illegal = illegal_reg;

endmodule
